// File: rtl/bch_byte_serializer.sv
// Byte-wide valid/ready input turned into an MSB-first serial bit stream,
// framed into K-bit BCH message blocks with zero padding after the last word.
module bch_byte_serializer #(
  parameter int unsigned K = 51,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sof,
  output logic         out_eob,
  output logic         out_last,
  output logic [5:0]   pad_cnt
);

  localparam int unsigned PW  = $clog2(K);
  localparam int unsigned BLW = $clog2(W + 1);
  localparam int unsigned IW  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sreg_q, sreg_d;
  logic [BLW-1:0]   bits_left_q, bits_left_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             last_flag_q, last_flag_d;
  logic [CW-1:0]    pad_cnt_q, pad_cnt_d;

  logic             in_ready_int;
  logic             out_valid_int;
  logic             out_bit_int;
  logic             last_block_bit;
  logic             word_end;
  logic             pos_end;
  logic [PW-1:0]    pos_inc;
  logic [IW-1:0]    bit_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bits_left_q <= '0;
      pos_q       <= '0;
      last_flag_q <= 1'b0;
      pad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
      pos_q       <= pos_d;
      last_flag_q <= last_flag_d;
      pad_cnt_q   <= pad_cnt_d;
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d        = state_q;
    sreg_d         = sreg_q;
    bits_left_d    = bits_left_q;
    pos_d          = pos_q;
    last_flag_d    = last_flag_q;
    pad_cnt_d      = pad_cnt_q;
    in_ready_int   = 1'b0;
    out_valid_int  = 1'b0;
    out_bit_int    = 1'b0;
    last_block_bit = 1'b0;

    word_end = (bits_left_q == BLW'(1));
    pos_end  = (pos_q == PW'(K - 1));
    pos_inc  = pos_end ? '0 : pos_q + PW'(1);
    bit_idx  = IW'(bits_left_q - BLW'(1));

    case (state_q)
      IDLE: begin
        in_ready_int = 1'b1;
        if (in_valid) begin
          sreg_d      = in_data;
          bits_left_d = BLW'(W);
          last_flag_d = in_last;
          state_d     = DATA;
        end
      end

      DATA: begin
        out_valid_int  = 1'b1;
        out_bit_int    = sreg_q[bit_idx];
        // Zero-bubble reload: accept the next word as the current one drains
        in_ready_int   = word_end & out_ready & ~last_flag_q;
        last_block_bit = last_flag_q & word_end;
        if (out_ready) begin
          pos_d       = pos_inc;
          bits_left_d = bits_left_q - BLW'(1);
          if (word_end) begin
            if (!last_flag_q) begin
              if (in_valid) begin
                sreg_d      = in_data;
                bits_left_d = BLW'(W);
                last_flag_d = in_last;
              end else begin
                state_d = IDLE;
              end
            end else begin
              pad_cnt_d = CW'(K - 1) - CW'(pos_q);
              state_d   = pos_end ? IDLE : PAD;
            end
          end
        end
      end

      PAD: begin
        out_valid_int  = 1'b1;
        last_block_bit = 1'b1;
        if (out_ready) begin
          pos_d = pos_inc;
          if (pos_end) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs forced low while reset is asserted
  assign in_ready  = ~rst & in_ready_int;
  assign out_valid = ~rst & out_valid_int;
  assign out_bit   = out_valid & out_bit_int;
  assign out_sof   = out_valid & (pos_q == '0);
  assign out_eob   = out_valid & pos_end;
  assign out_last  = out_eob & last_block_bit;
  assign pad_cnt   = pad_cnt_q;

endmodule
